// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue feeding the IF stage: streams sequential words from a
// multi-cycle instruction memory and drops queued and in-flight words on a redirect.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [31:0]      flush_pc,
  input  logic             deq,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  output logic [31:0]      inst_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      next_pc_out,
  output logic [PTR_W:0]   count
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] ONE  = {{PTR_W{1'b0}}, 1'b1};

  state_t             r_state;
  logic [PTR_W:0]     r_count;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [31:0]        r_fetchPc;
  logic               r_req;
  logic [31:0]        r_addr;
  logic [31:0]        r_memPc   [DEPTH];
  logic [31:0]        r_memInst [DEPTH];

  logic               w_push;
  logic               w_deq;
  logic [PTR_W:0]     w_nextCount;
  logic [31:0]        w_headPc;

  // A flush cancels both the push and the dequeue of its cycle.
  assign w_push = (r_state == WAIT) && imem_ack && !flush;
  assign w_deq  = deq && (r_count != '0) && !flush;

  always_comb begin
    w_nextCount = r_count;
    if (w_push && !w_deq)
      w_nextCount = r_count + ONE;
    else if (!w_push && w_deq)
      w_nextCount = r_count - ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_fetchPc <= RESET_PC;
      r_req     <= 1'b0;
      r_addr    <= RESET_PC;
    end else if (flush) begin
      r_count   <= '0;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_fetchPc <= flush_pc;
      // An unanswered request must still be retired, so its ack is absorbed in DISCARD.
      if (r_state != IDLE && !imem_ack) begin
        r_state <= DISCARD;
        r_req   <= 1'b1;
      end else begin
        r_state <= IDLE;
        r_req   <= 1'b0;
      end
    end else begin
      r_count <= w_nextCount;
      if (w_deq)
        r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push)
        r_wrPtr <= r_wrPtr + 1'b1;
      case (r_state)
        IDLE: begin
          if (r_count < FULL) begin
            r_state <= WAIT;
            r_req   <= 1'b1;
            r_addr  <= r_fetchPc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            r_fetchPc <= r_addr + 32'd4;
            if (w_nextCount < FULL) begin
              r_addr <= r_addr + 32'd4;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_memPc[r_wrPtr]   <= r_addr;
      r_memInst[r_wrPtr] <= imem_rdata;
    end
  end

  // Head is gated by occupancy so an empty queue presents a nop at pc 0.
  assign inst_valid  = (r_count != '0);
  assign w_headPc    = inst_valid ? r_memPc[r_rdPtr] : 32'h0;
  assign inst_out    = inst_valid ? r_memInst[r_rdPtr] : 32'h0;
  assign pc_out      = w_headPc;
  assign next_pc_out = w_headPc + 32'd4;
  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign count       = r_count;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed testbench for inst_prefetch_queue: fill, refill, discard, flush/ack collision,
// streaming with pointer wrap, and reset in mid-request.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        deq;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic [2:0]  count;

  int nChecks = 0;
  int nPassed = 0;

  inst_prefetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc), .deq(deq),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_out(inst_out),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .count(count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the word address.
  function automatic logic [31:0] wordAt(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign imem_rdata = wordAt(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; flush_pc = '0; deq = 1'b0; imem_ack = 1'b1;
    tick(); tick();
    nChecks++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", imem_req); else nPassed++;
    nChecks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", imem_addr); else nPassed++;
    nChecks++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else nPassed++;
    nChecks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", inst_valid); else nPassed++;
    nChecks++; if (inst_out !== 32'h0) $display("FAIL reset_inst got=%h exp=0", inst_out); else nPassed++;
    nChecks++; if (pc_out !== 32'h0) $display("FAIL reset_pc got=%h exp=0", pc_out); else nPassed++;
    nChecks++; if (next_pc_out !== 32'h4) $display("FAIL reset_npc got=%h exp=4", next_pc_out); else nPassed++;
  endtask

  task automatic test_fill();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nChecks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4))
        $display("FAIL fill_addr%0d got req=%0b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 32'(i * 4));
      else nPassed++;
    end
    tick();
    nChecks++; if (count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", count); else nPassed++;
    nChecks++; if (imem_req !== 1'b0) $display("FAIL fill_req got=%0b exp=0", imem_req); else nPassed++;
    nChecks++; if (inst_out !== wordAt(32'h0)) $display("FAIL fill_head got=%h exp=%h", inst_out, wordAt(32'h0)); else nPassed++;
    tick();
    nChecks++; if (imem_req !== 1'b0 || count !== 3'd4) $display("FAIL full_hold got req=%0b count=%0d exp req=0 count=4", imem_req, count); else nPassed++;
  endtask

  task automatic test_deq_refill();
    deq = 1'b1;
    tick();
    deq = 1'b0;
    nChecks++; if (count !== 3'd3) $display("FAIL deq_count got=%0d exp=3", count); else nPassed++;
    nChecks++; if (pc_out !== 32'h4 || next_pc_out !== 32'h8) $display("FAIL deq_pc got=%h/%h exp=4/8", pc_out, next_pc_out); else nPassed++;
    nChecks++; if (inst_out !== wordAt(32'h4)) $display("FAIL deq_inst got=%h exp=%h", inst_out, wordAt(32'h4)); else nPassed++;
    tick();
    imem_ack = 1'b0;
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL refill_req got req=%0b addr=%h exp req=1 addr=10", imem_req, imem_addr); else nPassed++;
  endtask

  task automatic test_discard();
    flush = 1'b1; flush_pc = 32'h40;
    tick();
    flush = 1'b0;
    nChecks++; if (count !== 3'd0 || inst_valid !== 1'b0) $display("FAIL discard_count got=%0d valid=%0b exp 0/0", count, inst_valid); else nPassed++;
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL discard_hold got req=%0b addr=%h exp req=1 addr=10", imem_req, imem_addr); else nPassed++;
    tick(); tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    nChecks++; if (count !== 3'd0 || imem_req !== 1'b0) $display("FAIL discard_drop got count=%0d req=%0b exp 0/0", count, imem_req); else nPassed++;
    tick();
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL redirect_req got req=%0b addr=%h exp req=1 addr=40", imem_req, imem_addr); else nPassed++;
  endtask

  task automatic test_flush_ack();
    flush = 1'b1; flush_pc = 32'h80; imem_ack = 1'b1;
    tick();
    flush = 1'b0; imem_ack = 1'b0;
    nChecks++; if (count !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL flushack_state got count=%0d valid=%0b req=%0b exp 0/0/0", count, inst_valid, imem_req); else nPassed++;
    tick();
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) $display("FAIL flushack_req got req=%0b addr=%h exp req=1 addr=80", imem_req, imem_addr); else nPassed++;
  endtask

  task automatic test_streaming();
    logic [31:0] expPc;
    deq = 1'b1; imem_ack = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      expPc = 32'h80 + 32'(4 * (k - 1));
      nChecks++;
      if (count !== 3'd1 || pc_out !== expPc || inst_out !== wordAt(expPc))
        $display("FAIL stream%0d got count=%0d pc=%h inst=%h exp count=1 pc=%h inst=%h", k, count, pc_out, inst_out, expPc, wordAt(expPc));
      else nPassed++;
    end
  endtask

  task automatic test_mid_reset();
    deq = 1'b0;
    tick();
    imem_ack = 1'b0;
    nChecks++; if (count !== 3'd2 || imem_req !== 1'b1) $display("FAIL prereset got count=%0d req=%0b exp 2/1", count, imem_req); else nPassed++;
    reset = 1'b0; imem_ack = 1'b1;
    tick();
    nChecks++; if (count !== 3'd0 || imem_req !== 1'b0 || imem_addr !== 32'h0) $display("FAIL midreset_ctl got count=%0d req=%0b addr=%h exp 0/0/0", count, imem_req, imem_addr); else nPassed++;
    nChecks++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0 || next_pc_out !== 32'h4) $display("FAIL midreset_head got valid=%0b inst=%h pc=%h npc=%h exp 0/0/0/4", inst_valid, inst_out, pc_out, next_pc_out); else nPassed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_deq_refill();
    test_discard();
    test_flush_ack();
    test_streaming();
    test_mid_reset();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
